// File: rtl/eq_vector_pkg.sv
// Shared types and vector field layout for the eq_vector_checker self-test engine.
// A table entry is packed as {a[N-1:0], b[N-1:0], exp}.
package eq_vector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int B_LSB   = 1;
  localparam int EXP_BIT = 0;

  // The a operand sits directly above b and the expected bit.
  function automatic int a_lsb(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/eq_vector_checker_if.sv
// Control and result bundle for eq_vector_checker.
// The master drives table writes and start; the slave drives the results.
interface eq_vector_checker_if #(
  parameter int N      = 2,
  parameter int ADDR_W = 3
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2*N:0]      wr_data;
  logic              start;
  logic              ready;
  logic              done_tick;
  logic [ADDR_W:0]   pass_cnt;
  logic [ADDR_W:0]   fail_cnt;
  logic              fail_valid;
  logic [ADDR_W-1:0] first_fail_addr;
  logic [N-1:0]      cur_a;
  logic [N-1:0]      cur_b;
  logic              cur_eq;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  ready, done_tick, pass_cnt, fail_cnt, fail_valid, first_fail_addr,
           cur_a, cur_b, cur_eq
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output ready, done_tick, pass_cnt, fail_cnt, fail_valid, first_fail_addr,
           cur_a, cur_b, cur_eq
  );

endinterface

// File: rtl/eq_vector_ram.sv
// Simple dual-port vector table: one synchronous write port, one registered read port.
// No reset on the storage so it maps onto block RAM.
module eq_vector_ram #(
  parameter int WIDTH  = 5,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/eq_vector_checker.sv
// On-chip self-test engine: replays a table of {a, b, exp} vectors through an N-bit
// equality comparator and reports pass/fail counts. Optional macro: EQV_STOP_ON_FAIL_EN.
module eq_vector_checker #(
  parameter int N      = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic               clk,
  input logic               reset,
  eq_vector_checker_if.slave bus
);

  import eq_vector_pkg::*;

  localparam int                WIDTH = 2 * N + 1;
  localparam int                A_LSB = a_lsb(N);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_valid;
  logic [WIDTH-1:0]  rd_data;

  logic [N-1:0] chk_a;
  logic [N-1:0] chk_b;
  logic         chk_eq;
  logic         chk_mismatch;
  logic         halt;
  logic         check_en;

  eq_vector_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (bus.wr_en && (state == IDLE)),
    .waddr(bus.wr_addr),
    .wdata(bus.wr_data),
    .re   (state == RUN),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign chk_a        = rd_data[A_LSB +: N];
  assign chk_b        = rd_data[B_LSB +: N];
  assign chk_eq       = (chk_a == chk_b);
  assign chk_mismatch = chk_eq ^ rd_data[EXP_BIT];

  // When stopping on failure, anything read after the first mismatch is discarded.
`ifdef EQV_STOP_ON_FAIL_EN
  assign halt = bus.fail_valid;
`else
  assign halt = 1'b0;
`endif

  assign check_en = chk_valid && !halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      rd_addr             <= '0;
      chk_addr            <= '0;
      chk_valid           <= 1'b0;
      bus.ready           <= 1'b1;
      bus.done_tick       <= 1'b0;
      bus.pass_cnt        <= '0;
      bus.fail_cnt        <= '0;
      bus.fail_valid      <= 1'b0;
      bus.first_fail_addr <= '0;
      bus.cur_a           <= '0;
      bus.cur_b           <= '0;
      bus.cur_eq          <= 1'b0;
    end else begin
      bus.done_tick <= 1'b0;
      chk_valid     <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.pass_cnt        <= '0;
            bus.fail_cnt        <= '0;
            bus.fail_valid      <= 1'b0;
            bus.first_fail_addr <= '0;
            rd_addr             <= '0;
            bus.ready           <= 1'b0;
            state               <= RUN;
          end
        end
        RUN: begin
          if (halt) begin
            bus.done_tick <= 1'b1;
            state         <= DONE;
          end else begin
            chk_valid <= 1'b1;
            chk_addr  <= rd_addr;
            rd_addr   <= rd_addr + 1'b1;
            if (rd_addr == LAST) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          bus.done_tick <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // The check stage trails the table read by one cycle.
      if (check_en) begin
        bus.cur_a  <= chk_a;
        bus.cur_b  <= chk_b;
        bus.cur_eq <= chk_eq;
        if (chk_mismatch) begin
          bus.fail_cnt <= bus.fail_cnt + 1'b1;
          if (!bus.fail_valid) begin
            bus.fail_valid      <= 1'b1;
            bus.first_fail_addr <= chk_addr;
          end
        end else begin
          bus.pass_cnt <= bus.pass_cnt + 1'b1;
        end
      end
    end
  end

endmodule
